// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the program sequencer:
//   - opcode encodings (3-bit field at the top of every instruction word)
//   - sequencer state encoding (2 bits)
//   - reset image of the instruction memory (8-bit reference words)
// No ports; imported by seq_imem and program_sequencer.
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NOP = 3'b011;
  localparam logic [2:0] OP_RSV = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // Reset image in 8-bit form: {opcode[2:0], operand[4:0]}.
  localparam logic [7:0] IMG_ADD3 = 8'h03;
  localparam logic [7:0] IMG_SUB2 = 8'h22;
  localparam logic [7:0] IMG_MUL5 = 8'h45;
  localparam logic [7:0] IMG_JMP0 = 8'hC0;
  localparam logic [7:0] IMG_NOP  = 8'h60;

  function automatic logic [7:0] reset_word(int unsigned idx);
    case (idx)
      0:       return IMG_ADD3;
      1:       return IMG_SUB2;
      2:       return IMG_MUL5;
      3:       return IMG_JMP0;
      default: return IMG_NOP;
    endcase
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// -----------------------------------------------------------------------------
// program_sequencer_if
// Bundles the control/load inputs and fetch outputs of the program sequencer.
//   master: top level / bench side (drives ena, start, load_*, zero_flag)
//   slave : sequencer side (drives instr_out, instr_valid, pc_out, busy, halted)
// -----------------------------------------------------------------------------
interface program_sequencer_if #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 4
);
  logic               ena;
  logic               start;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               zero_flag;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc_out;
  logic               busy;
  logic               halted;

  modport master (
    output ena, start, load_en, load_addr, load_data, zero_flag,
    input  instr_out, instr_valid, pc_out, busy, halted
  );

  modport slave (
    input  ena, start, load_en, load_addr, load_data, zero_flag,
    output instr_out, instr_valid, pc_out, busy, halted
  );
endinterface

// File: rtl/seq_imem.sv
// -----------------------------------------------------------------------------
// seq_imem
// DEPTH x INSTR_W flop-array instruction memory.
//   clock, reset_n : clock / async active-low reset (reloads the reset image)
//   we, waddr, wdata : synchronous write port (addresses >= DEPTH are dropped)
//   raddr, rdata     : combinational read port (addresses >= DEPTH read NOP)
// -----------------------------------------------------------------------------
module seq_imem
  import seq_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int OPND_W = INSTR_W - 3;

  // Re-pack an 8-bit reference word so the opcode stays in the top 3 bits.
  function automatic logic [INSTR_W-1:0] widen(logic [7:0] w);
    return {w[7:5], OPND_W'(w[4:0])};
  endfunction

  logic [INSTR_W-1:0] mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        mem[g] <= widen(reset_word(g));
      end else if (we && (waddr == ADDR_W'(g))) begin
        mem[g] <= wdata;
      end
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : widen(IMG_NOP);

endmodule

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Writable instruction memory plus PC with jump / conditional branch / halt.
// Fetches one word per enabled RUN cycle; data ops (opcodes 000..100) are
// forwarded on instr_out with a one-cycle instr_valid strobe, control ops
// (JZ, JMP, HLT) are consumed here.
//   clock, reset_n : clock / async active-low reset
//   bus (slave)    : ena, start, load_en/addr/data, zero_flag in;
//                    instr_out, instr_valid, pc_out, busy, halted out
// -----------------------------------------------------------------------------
module program_sequencer
  import seq_pkg::*;
#(
  parameter int INSTR_W   = 8,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int LAST_ADDR = DEPTH - 1
) (
  input  logic                clock,
  input  logic                reset_n,
  program_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  seq_state_t         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;
  logic               busy_q;
  logic               halted_q;

  logic [INSTR_W-1:0] word_p0;
  logic [2:0]         opcode_p0;
  logic [ADDR_W-1:0]  target_p0;
  logic [ADDR_W-1:0]  pc_next_p0;
  logic               mem_we;
  logic               unused_opnd;

  // Loads only land while the program is not executing.
  assign mem_we = bus.load_en && (state != ST_RUN);

  seq_imem #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_imem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (bus.load_addr),
    .wdata   (bus.load_data),
    .raddr   (pc),
    .rdata   (word_p0)
  );

  // Fetch stage (p0): decode the word at pc combinationally.
  assign opcode_p0  = word_p0[INSTR_W-1 -: 3];
  // Targets use only the low ADDR_W operand bits, so jumps wrap modulo 2**ADDR_W.
  assign target_p0  = word_p0[ADDR_W-1:0];
  assign pc_next_p0 = (pc == LAST) ? '0 : pc + 1'b1;
  assign unused_opnd = ^word_p0[INSTR_W-4:ADDR_W];

  // Issue stage (p1): FSM, PC and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            state    <= ST_RUN;
            pc       <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.ena) begin
            case (opcode_p0)
              OP_JMP: pc <= target_p0;
              OP_JZ:  pc <= bus.zero_flag ? target_p0 : pc_next_p0;
              OP_HLT: begin
                state    <= ST_HALT;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end
              default: begin
                instr_p1 <= word_p0;
                vld_p1   <= 1'b1;
                pc       <= pc_next_p0;
              end
            endcase
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_out   = instr_p1;
  assign bus.instr_valid = vld_p1;
  assign bus.pc_out      = pc;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Directed bench for program_sequencer: dut_a uses the full 16-entry program
// space, dut_b wraps after address 5. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  program_sequencer_if #(.INSTR_W(8), .ADDR_W(4)) if_a ();
  program_sequencer_if #(.INSTR_W(8), .ADDR_W(4)) if_b ();

  program_sequencer #(.INSTR_W(8), .ADDR_W(4), .DEPTH(16), .LAST_ADDR(15)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  program_sequencer #(.INSTR_W(8), .ADDR_W(4), .DEPTH(16), .LAST_ADDR(5)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic load_a(input logic [3:0] addr, input logic [7:0] data);
    if_a.load_en = 1'b1; if_a.load_addr = addr; if_a.load_data = data;
    tick();
    if_a.load_en = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] addr, input logic [7:0] data);
    if_b.load_en = 1'b1; if_b.load_addr = addr; if_b.load_data = data;
    tick();
    if_b.load_en = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({if_a.pc_out, if_a.instr_out, if_a.instr_valid, if_a.busy, if_a.halted} !== 15'd0) begin
      errors++;
      $display("FAIL reset_a: pc=%0d instr=%h vld=%b busy=%b halted=%b, expected all zero",
               if_a.pc_out, if_a.instr_out, if_a.instr_valid, if_a.busy, if_a.halted);
    end
    checks++;
    if ({if_b.pc_out, if_b.instr_out, if_b.instr_valid, if_b.busy, if_b.halted} !== 15'd0) begin
      errors++;
      $display("FAIL reset_b: pc=%0d instr=%h vld=%b busy=%b halted=%b, expected all zero",
               if_b.pc_out, if_b.instr_out, if_b.instr_valid, if_b.busy, if_b.halted);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_default_program();
    logic [7:0] ei [6] = '{8'h03, 8'h22, 8'h45, 8'h45, 8'h03, 8'h22};
    logic       ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] ep [6] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
    if_a.zero_flag = 1'b0; if_a.ena = 1'b1; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    checks++;
    if (if_a.busy !== 1'b1 || if_a.pc_out !== 4'd0 || if_a.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL default_start: busy=%b pc=%0d vld=%b, expected busy=1 pc=0 vld=0",
               if_a.busy, if_a.pc_out, if_a.instr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (if_a.instr_out !== ei[k] || if_a.instr_valid !== ev[k] || if_a.pc_out !== ep[k]) begin
        errors++;
        $display("FAIL default_seq[%0d]: instr=%h vld=%b pc=%0d, expected instr=%h vld=%b pc=%0d",
                 k, if_a.instr_out, if_a.instr_valid, if_a.pc_out, ei[k], ev[k], ep[k]);
      end
    end
  endtask

  task automatic test_jz_halt();
    logic [7:0] ei [5];
    logic       ev [5];
    logic [3:0] ep [5];
    logic       eh [5];
    if_a.ena = 1'b0;
    do_reset();
    load_a(4'd0, 8'h02);
    load_a(4'd1, 8'hA3);
    load_a(4'd3, 8'hE0);
    // Taken branch: ADD 2, JZ 3 -> HLT.
    if_a.zero_flag = 1'b1; if_a.ena = 1'b1; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    ei = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    ev = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ep = '{4'd1, 4'd3, 4'd3, 4'd3, 4'd3};
    eh = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (if_a.instr_out !== ei[k] || if_a.instr_valid !== ev[k] || if_a.pc_out !== ep[k] ||
          if_a.halted !== eh[k] || if_a.busy !== !eh[k]) begin
        errors++;
        $display("FAIL jz_taken[%0d]: instr=%h vld=%b pc=%0d halted=%b busy=%b, expected instr=%h vld=%b pc=%0d halted=%b busy=%b",
                 k, if_a.instr_out, if_a.instr_valid, if_a.pc_out, if_a.halted, if_a.busy,
                 ei[k], ev[k], ep[k], eh[k], !eh[k]);
      end
    end
    // Not taken: reload mem[2] while halted, restart from HALT.
    load_a(4'd2, 8'h22);
    if_a.zero_flag = 1'b0; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    checks++;
    if (if_a.busy !== 1'b1 || if_a.halted !== 1'b0 || if_a.pc_out !== 4'd0) begin
      errors++;
      $display("FAIL restart_halt: busy=%b halted=%b pc=%0d, expected busy=1 halted=0 pc=0",
               if_a.busy, if_a.halted, if_a.pc_out);
    end
    ei = '{8'h02, 8'h02, 8'h22, 8'h22, 8'h22};
    ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ep = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    eh = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (if_a.instr_out !== ei[k] || if_a.instr_valid !== ev[k] || if_a.pc_out !== ep[k] ||
          if_a.halted !== eh[k]) begin
        errors++;
        $display("FAIL jz_not_taken[%0d]: instr=%h vld=%b pc=%0d halted=%b, expected instr=%h vld=%b pc=%0d halted=%b",
                 k, if_a.instr_out, if_a.instr_valid, if_a.pc_out, if_a.halted,
                 ei[k], ev[k], ep[k], eh[k]);
      end
    end
  endtask

  task automatic test_run_controls();
    // Program is 02, A3, 22, E0 with zero_flag=0; dut_a is halted.
    if_a.ena = 1'b1; if_a.start = 1'b1;
    tick();
    // start held high in RUN must not reset the PC.
    tick();
    checks++;
    if (if_a.instr_out !== 8'h02 || if_a.instr_valid !== 1'b1 || if_a.pc_out !== 4'd1) begin
      errors++;
      $display("FAIL start_in_run: instr=%h vld=%b pc=%0d, expected instr=02 vld=1 pc=1",
               if_a.instr_out, if_a.instr_valid, if_a.pc_out);
    end
    if_a.start = 1'b0; if_a.ena = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (if_a.instr_out !== 8'h02 || if_a.instr_valid !== 1'b0 || if_a.pc_out !== 4'd1) begin
        errors++;
        $display("FAIL stall[%0d]: instr=%h vld=%b pc=%0d, expected instr=02 vld=0 pc=1",
                 k, if_a.instr_out, if_a.instr_valid, if_a.pc_out);
      end
    end
    if_a.ena = 1'b1;
    if_a.load_en = 1'b1; if_a.load_addr = 4'd2; if_a.load_data = 8'h00;
    tick();
    if_a.load_en = 1'b0;
    checks++;
    if (if_a.instr_valid !== 1'b0 || if_a.pc_out !== 4'd2) begin
      errors++;
      $display("FAIL resume_jz: vld=%b pc=%0d, expected vld=0 pc=2", if_a.instr_valid, if_a.pc_out);
    end
    tick();
    checks++;
    if (if_a.instr_out !== 8'h22 || if_a.instr_valid !== 1'b1 || if_a.pc_out !== 4'd3) begin
      errors++;
      $display("FAIL load_in_run: instr=%h vld=%b pc=%0d, expected instr=22 vld=1 pc=3",
               if_a.instr_out, if_a.instr_valid, if_a.pc_out);
    end
    tick();
    checks++;
    if (if_a.halted !== 1'b1 || if_a.pc_out !== 4'd3) begin
      errors++;
      $display("FAIL halt_again: halted=%b pc=%0d, expected halted=1 pc=3", if_a.halted, if_a.pc_out);
    end
  endtask

  task automatic test_start_with_load();
    if_a.load_en = 1'b1; if_a.load_addr = 4'd0; if_a.load_data = 8'h45;
    if_a.start = 1'b1;
    tick();
    if_a.load_en = 1'b0; if_a.start = 1'b0;
    checks++;
    if (if_a.busy !== 1'b1 || if_a.pc_out !== 4'd0) begin
      errors++;
      $display("FAIL start_load_state: busy=%b pc=%0d, expected busy=1 pc=0", if_a.busy, if_a.pc_out);
    end
    tick();
    checks++;
    if (if_a.instr_out !== 8'h45 || if_a.instr_valid !== 1'b1 || if_a.pc_out !== 4'd1) begin
      errors++;
      $display("FAIL start_load_fetch: instr=%h vld=%b pc=%0d, expected instr=45 vld=1 pc=1",
               if_a.instr_out, if_a.instr_valid, if_a.pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ei [7] = '{8'h03, 8'h22, 8'h45, 8'h04, 8'h25, 8'h46, 8'h03};
    logic [3:0] ep [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    if_a.ena = 1'b0;
    do_reset();
    load_b(4'd3, 8'h04);
    load_b(4'd4, 8'h25);
    load_b(4'd5, 8'h46);
    if_b.zero_flag = 1'b0; if_b.ena = 1'b1; if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (if_b.instr_out !== ei[k] || if_b.instr_valid !== 1'b1 || if_b.pc_out !== ep[k]) begin
        errors++;
        $display("FAIL wrap[%0d]: instr=%h vld=%b pc=%0d, expected instr=%h vld=1 pc=%0d",
                 k, if_b.instr_out, if_b.instr_valid, if_b.pc_out, ei[k], ep[k]);
      end
    end
    if_b.ena = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    if_a.zero_flag = 1'b0; if_a.ena = 1'b1; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if_a.pc_out, if_a.instr_out, if_a.instr_valid, if_a.busy, if_a.halted} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: pc=%0d instr=%h vld=%b busy=%b halted=%b, expected all zero",
               if_a.pc_out, if_a.instr_out, if_a.instr_valid, if_a.busy, if_a.halted);
    end
    @(negedge clock);
    reset_n = 1'b1;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    tick();
    checks++;
    if (if_a.instr_out !== 8'h03 || if_a.instr_valid !== 1'b1 || if_a.pc_out !== 4'd1) begin
      errors++;
      $display("FAIL replay0: instr=%h vld=%b pc=%0d, expected instr=03 vld=1 pc=1",
               if_a.instr_out, if_a.instr_valid, if_a.pc_out);
    end
    tick();
    checks++;
    if (if_a.instr_out !== 8'h22 || if_a.instr_valid !== 1'b1 || if_a.pc_out !== 4'd2) begin
      errors++;
      $display("FAIL replay1: instr=%h vld=%b pc=%0d, expected instr=22 vld=1 pc=2",
               if_a.instr_out, if_a.instr_valid, if_a.pc_out);
    end
  endtask

  initial begin
    if_a.ena = 1'b0; if_a.start = 1'b0; if_a.load_en = 1'b0;
    if_a.load_addr = '0; if_a.load_data = '0; if_a.zero_flag = 1'b0;
    if_b.ena = 1'b0; if_b.start = 1'b0; if_b.load_en = 1'b0;
    if_b.load_addr = '0; if_b.load_data = '0; if_b.zero_flag = 1'b0;
    test_reset();
    test_default_program();
    test_jz_halt();
    test_run_controls();
    test_start_with_load();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program sequencer for CPU mode 1: a writable instruction memory plus a program counter with jump, conditional-branch and halt control. It succeeds the fixed 4-entry PC/ROM. It fetches one instruction per enabled cycle and forwards data instructions (ADD/SUB/MUL/…) to the ALU path with a valid strobe. It consumes control instructions internally. It sits between the top level (which loads and starts programs) and the ALU/accumulator datapath, which returns a zero flag.

## Interface
- INSTR_W, 8: instruction width; opcode = [INSTR_W-1:INSTR_W-3], operand = [INSTR_W-4:0]
- ADDR_W, 4: PC / memory address width
- DEPTH, 16: memory entries, ≤ 2**ADDR_W
- LAST_ADDR, DEPTH-1: address after which the PC wraps to 0

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  advance enable in RUN (stall when 0)
- start  in  1  pulse; IDLE/HALT → RUN, PC ← 0
- load_en  in  1  program write strobe (IDLE/HALT only)
- load_addr  in  ADDR_W  write address
- load_data  in  INSTR_W  write data
- zero_flag  in  1  ALU accumulator == 0, sampled for JZ
- instr_out  out  INSTR_W  last issued data instruction (registered)
- instr_valid  out  1  one-cycle strobe per issued data instruction
- pc_out  out  ADDR_W  current PC
- busy  out  1  state == RUN
- halted  out  1  state == HALT

## Operation
- States: IDLE (after reset), RUN, HALT. IDLE/HALT --start--> RUN. RUN --HLT fetched with ena--> HALT. No other transitions.
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 NOP, 100 reserved data op (all data, forwarded); 101 JZ, 110 JMP, 111 HLT (control, never forwarded).
- Target = operand[ADDR_W-1:0]. A target > LAST_ADDR is taken modulo: PC ← target & mask, then wraps normally. Out-of-DEPTH reads return NOP.
- RUN, ena=1, per cycle: read mem[pc] combinationally.
  - Data op: instr_out ← word, instr_valid ← 1, PC ← (pc==LAST_ADDR) ? 0 : pc+1.
  - JMP: PC ← target.
  - JZ: PC ← zero_flag ? target : sequential next.
  - HLT: PC holds, state → HALT.
  - Control ops: instr_valid ← 0; instr_out holds.
- RUN, ena=0: PC, instr_out hold; instr_valid ← 0.
- load_en writes mem[load_addr] at the edge only in IDLE/HALT. It is ignored in RUN.
- start in RUN is ignored. start with load_en in the same cycle: the write lands and RUN begins. The first fetch (next cycle) sees the new word.
- Memory reset image: 0: ADD 3 (00000011), 1: SUB 2 (00100010), 2: MUL 5 (01000101), 3: JMP 0 (11000000), rest NOP (01100000).

## Timing
- Reset (async assert, sync release) gives: state IDLE, PC 0, instr_out 0, instr_valid 0, busy 0, halted 0, memory at the reset image. Reset mid-RUN aborts immediately and discards loaded programs.
- Fetch-to-output latency is 1 cycle: the word at pc during cycle N appears on instr_out/instr_valid after edge N.
- Throughput is one instruction per enabled cycle. Jumps cost zero bubbles, but each control op produces one cycle with instr_valid=0.
- zero_flag is sampled in the same cycle the JZ is fetched. The ALU result of the preceding data op must be visible by then: its accumulator updates on the edge that issues the op.
- pc_out is the registered PC, not a pipeline copy.

## Structure
- Package seq_pkg holds the opcode localparams (OP_ADD…OP_HLT), the state encoding (ST_IDLE/ST_RUN/ST_HALT, 2 bits) and the reset-image words.
- Sub-module seq_imem is a DEPTH×INSTR_W flop array with async reset-to-image, one write port and one combinational read port. The sequencer holds the FSM, PC and output registers.

## Test plan
- Reset, start, ena=1 with zero_flag=0 → instr_out sequence 0x03, 0x22, 0x45 with valid=1; one cycle with valid=0 (JMP 0); repeats; pc_out 0,1,2,3,0.
- In IDLE, load mem[0]=0x02, mem[1]=0xA3 (JZ 3), mem[3]=0xE0 (HLT); start with zero_flag=1 → one ADD 2 issued, then halted=1, busy=0, pc_out=3. Repeat with zero_flag=0 → pc goes 1→2 and issues SUB 2.
- With LAST_ADDR=5, program of six data ops → pc wraps 5→0 with no bubble.
- Toggle ena 1,0,0,1 in RUN → pc and instr_out hold for two cycles, instr_valid low in both.
- load_en asserted during RUN → memory unchanged. Assert start in RUN → no PC reset. Assert start in HALT → restart at pc 0.
- Assert reset_n low mid-RUN between edges → outputs zero immediately. After release, the default program replays from 0.
